// File: rtl/ex_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_stage_pkg
// Purpose : WISC opcode constants and the per-opcode flag-update classifier.
// Revision: 1.0
// ============================================================================
package ex_mem_stage_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   // Returns {upd_z, upd_n, upd_v}; the branch logic shares this classifier.
   function automatic logic [2:0] flag_upd_class(input logic [3:0] op);
      logic [2:0] upd;
      upd = 3'b000;
      case (op)
         OP_ADD, OP_SUB:                 upd = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: upd = 3'b100;
         default:                        upd = 3'b000;
      endcase
      return upd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_mem_stage_flag_reg.sv
`default_nettype none
// ============================================================================
// Module  : flag_reg
// Purpose : Architectural Z/N/V flag flops with per-bit enables and stall.
// Revision: 1.0
// ============================================================================
module flag_reg (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall_i,
   input  logic [2:0] en_i,
   input  logic [2:0] d_i,
   output logic [2:0] flags_o
);
   logic [2:0] flags_q;
   logic [2:0] flags_d;

   always_comb begin
      flags_d = flags_q;
      if (!stall_i) begin
         flags_d = (en_i & d_i) | (~en_i & flags_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags_o = flags_q;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_mem_stage
// Purpose : EX/MEM pipeline register with flag ownership, stall/flush, halt.
// Revision: 1.0
// ============================================================================
module ex_mem_stage
   import ex_mem_stage_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [3:0]            ex_opcode,
   input  logic [DATA_W-1:0]     ex_result,
   input  logic                  ex_ovfl,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [DATA_W-1:0]     ex_store_data,
   output logic                  mem_valid,
   output logic [3:0]            mem_opcode,
   output logic [DATA_W-1:0]     mem_result,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_reg_write,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic [DATA_W-1:0]     mem_store_data,
   output logic                  mem_halt,
   output logic                  flag_z,
   output logic                  flag_v,
   output logic                  flag_n
);
   logic                  valid_q,     valid_d;
   logic [3:0]            opcode_q,    opcode_d;
   logic [DATA_W-1:0]     result_q,    result_d;
   logic [REG_ADDR_W-1:0] rd_q,        rd_d;
   logic                  reg_write_q, reg_write_d;
   logic                  mem_read_q,  mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [DATA_W-1:0]     store_q,     store_d;
   logic                  halt_q,      halt_d;

   logic       capture;
   logic [2:0] flag_en;
   logic [2:0] flag_val;
   logic [2:0] flags;

   // Once halted, nothing more enters MEM until reset.
   assign capture  = ~stall & ~flush & ex_valid & ~halt_q;
   assign flag_en  = {3{capture}} & flag_upd_class(ex_opcode);
   assign flag_val = {(ex_result == '0), ex_result[DATA_W-1], ex_ovfl};

   always_comb begin
      valid_d     = valid_q;
      opcode_d    = opcode_q;
      result_d    = result_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      store_d     = store_q;
      halt_d      = halt_q;
      if (!stall) begin
         valid_d     = capture;
         reg_write_d = capture & ex_reg_write;
         mem_read_d  = capture & ex_mem_read;
         mem_write_d = capture & ex_mem_write;
         if (capture) begin
            opcode_d = ex_opcode;
            result_d = ex_result;
            rd_d     = ex_rd;
            store_d  = ex_store_data;
            halt_d   = (ex_opcode == OP_HLT);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         opcode_q    <= '0;
         result_q    <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         store_q     <= '0;
         halt_q      <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         opcode_q    <= opcode_d;
         result_q    <= result_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         store_q     <= store_d;
         halt_q      <= halt_d;
      end
   end

   flag_reg u_flag_reg (
      .clk     (clk),
      .rst     (rst),
      .stall_i (stall),
      .en_i    (flag_en),
      .d_i     (flag_val),
      .flags_o (flags)
   );

   assign mem_valid      = valid_q;
   assign mem_opcode     = opcode_q;
   assign mem_result     = result_q;
   assign mem_rd         = rd_q;
   assign mem_reg_write  = reg_write_q;
   assign mem_mem_read   = mem_read_q;
   assign mem_mem_write  = mem_write_q;
   assign mem_store_data = store_q;
   assign mem_halt       = halt_q;
   assign flag_z         = flags[2];
   assign flag_n         = flags[1];
   assign flag_v         = flags[0];

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_mem_stage
// Purpose : Self-checking bench for ex_mem_stage against a rule-level model.
// Revision: 1.0
// ============================================================================
module tb_ex_mem_stage;
   logic        clk = 1'b0;
   logic        rst, stall, flush, ex_valid, ex_ovfl;
   logic [3:0]  ex_opcode, ex_rd;
   logic [15:0] ex_result, ex_store_data;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
   logic [3:0]  mem_opcode, mem_rd;
   logic [15:0] mem_result, mem_store_data;
   logic        flag_z, flag_v, flag_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic        m_valid, m_rw, m_mr, m_mw, m_halt, m_z, m_v, m_n, m_known;
   logic [3:0]  m_op, m_rd;
   logic [15:0] m_res, m_sd;

   ex_mem_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
      .ex_opcode(ex_opcode), .ex_result(ex_result), .ex_ovfl(ex_ovfl),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data),
      .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data),
      .mem_halt(mem_halt), .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] dut_vec();
      return {mem_valid, mem_opcode, mem_result, mem_rd, mem_reg_write,
              mem_mem_read, mem_mem_write, mem_store_data, mem_halt,
              flag_z, flag_v, flag_n};
   endfunction

   function automatic logic [47:0] exp_vec();
      return {m_valid, m_op, m_res, m_rd, m_rw, m_mr, m_mw, m_sd, m_halt,
              m_z, m_v, m_n};
   endfunction

   // Data fields of a bubble are don't-care.
   function automatic logic [47:0] exp_mask();
      return m_known ? {48{1'b1}} : {1'b1, 4'h0, 16'h0, 4'h0, 3'b111, 16'h0, 4'hF};
   endfunction

   // Rule-level model applied at each rising edge using the presented inputs.
   task automatic model_edge();
      if (rst) begin
         {m_valid, m_rw, m_mr, m_mw, m_halt, m_z, m_v, m_n} = '0;
         m_op = 0; m_rd = 0; m_res = 0; m_sd = 0; m_known = 1'b1;
      end else if (stall) begin
         // everything holds
      end else if (!flush && ex_valid && !m_halt) begin
         m_valid = 1; m_op = ex_opcode; m_res = ex_result; m_rd = ex_rd;
         m_rw = ex_reg_write; m_mr = ex_mem_read; m_mw = ex_mem_write;
         m_sd = ex_store_data; m_known = 1'b1;
         if (ex_opcode == 4'd0 || ex_opcode == 4'd1) begin
            m_z = (ex_result == 16'd0); m_n = ex_result[15]; m_v = ex_ovfl;
         end else if (ex_opcode == 4'd2 || ex_opcode == 4'd4 ||
                      ex_opcode == 4'd5 || ex_opcode == 4'd6) begin
            m_z = (ex_result == 16'd0);
         end
         if (ex_opcode == 4'd15) m_halt = 1'b1;
      end else begin
         m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_known = 1'b0;
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic f, input logic v,
                        input logic [3:0] op, input logic [15:0] res, input logic ov,
                        input logic [3:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic [15:0] sd);
      rst = r; stall = s; flush = f; ex_valid = v; ex_opcode = op; ex_result = res;
      ex_ovfl = ov; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
      ex_mem_write = mw; ex_store_data = sd;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0, 4'h0, 16'hFFFF, 1, 4'hF, 1, 1, 1, 16'hFFFF);
      tick(); tick();
      n_tests++;
      if (dut_vec() !== 48'h0) begin
         n_fail++; $display("FAIL reset: got %h required 0", dut_vec());
      end
      drive(0, 0, 0, 0, 4'h0, 16'h1234, 1, 4'h3, 1, 1, 1, 16'h5678);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if ((dut_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
            n_fail++;
            $display("FAIL reset_bubble%0d: got %h required %h", i,
                     dut_vec() & exp_mask(), exp_vec() & exp_mask());
         end
      end
   endtask

   task automatic test_add_flags();
      drive(0, 0, 0, 1, 4'h0, 16'h8000, 1, 4'h5, 1, 0, 0, 16'h00AA);
      tick();
      n_tests++;
      if ({mem_valid, mem_result, flag_z, flag_n, flag_v} !== {1'b1, 16'h8000, 3'b011}) begin
         n_fail++;
         $display("FAIL add_flags: got v=%b res=%h znv=%b%b%b required v=1 res=8000 znv=011",
                  mem_valid, mem_result, flag_z, flag_n, flag_v);
      end
      drive(0, 0, 0, 1, 4'h4, 16'h0000, 0, 4'h6, 1, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if ({flag_z, flag_n, flag_v} !== 3'b111 || exp_vec() !== dut_vec()) begin
         n_fail++;
         $display("FAIL sll_flags: got %h required %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_flag_neutral();
      drive(0, 0, 0, 1, 4'h5, 16'h0004, 1, 4'h7, 1, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if ({flag_z, flag_n, flag_v} !== 3'b011) begin
         n_fail++;
         $display("FAIL sra_flags: got znv=%b%b%b required 011", flag_z, flag_n, flag_v);
      end
      drive(0, 0, 0, 1, 4'h8, 16'h0000, 0, 4'h9, 1, 1, 0, 16'hBEEF);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec() || mem_mem_read !== 1'b1 || mem_rd !== 4'h9 ||
          {flag_z, flag_n, flag_v} !== 3'b011) begin
         n_fail++;
         $display("FAIL lw_neutral: got %h required %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_stall_flush();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 1, 4'h1, 16'($urandom), 1'($urandom), 4'($urandom), 1, 1, 1,
               16'($urandom));
         tick();
         n_tests++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall%0d: got %h required %h", i, dut_vec(), exp_vec());
         end
      end
      drive(0, 1, 1, 1, 4'h0, 16'h0000, 0, 4'h2, 1, 0, 1, 16'h1111);
      tick();
      n_tests++;
      if (dut_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL stall_flush: got %h required %h", dut_vec(), exp_vec());
      end
      drive(0, 0, 1, 1, 4'h0, 16'h0000, 0, 4'h2, 1, 0, 0, 16'h1111);
      tick();
      n_tests++;
      if (mem_valid !== 1'b0 || mem_reg_write !== 1'b0 || flag_z !== 1'b0 ||
          (dut_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
         n_fail++;
         $display("FAIL flush: got v=%b rw=%b z=%b required v=0 rw=0 z=0",
                  mem_valid, mem_reg_write, flag_z);
      end
   endtask

   task automatic test_halt();
      drive(0, 0, 0, 1, 4'hF, 16'h0042, 0, 4'h0, 0, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if (mem_halt !== 1'b1 || mem_valid !== 1'b1 || mem_opcode !== 4'hF) begin
         n_fail++;
         $display("FAIL halt_cap: got halt=%b v=%b op=%h required 1 1 f",
                  mem_halt, mem_valid, mem_opcode);
      end
      drive(0, 0, 0, 1, 4'h0, 16'h0000, 1, 4'h3, 1, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if (mem_valid !== 1'b0 || mem_halt !== 1'b1 || flag_z !== 1'b0 ||
          (dut_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
         n_fail++;
         $display("FAIL halt_bubble: got %h required %h",
                  dut_vec() & exp_mask(), exp_vec() & exp_mask());
      end
      drive(0, 0, 1, 0, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if (mem_halt !== 1'b1) begin
         n_fail++; $display("FAIL halt_flush: got halt=%b required 1", mem_halt);
      end
      drive(1, 0, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 0, 0, 0, 16'h0000);
      tick();
      n_tests++;
      if (mem_halt !== 1'b0 || dut_vec() !== 48'h0) begin
         n_fail++; $display("FAIL halt_rst: got %h required 0", dut_vec());
      end
   endtask

   task automatic test_reset_midstream();
      drive(0, 0, 0, 1, 4'h1, 16'hF000, 1, 4'hC, 1, 0, 1, 16'hCAFE);
      tick();
      drive(1, 1, 0, 1, 4'h1, 16'h0000, 1, 4'hD, 1, 0, 0, 16'h0001);
      tick();
      n_tests++;
      if (dut_vec() !== 48'h0) begin
         n_fail++; $display("FAIL rst_mid: got %h required 0", dut_vec());
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int i = 0; i < 400; i++) begin
         op = 4'($urandom);
         if (op == 4'hF && ($urandom_range(0, 3) != 0)) op = 4'h0;
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0), op,
               ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 1'($urandom),
               4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
         tick();
         n_tests++;
         if ((dut_vec() & exp_mask()) !== (exp_vec() & exp_mask())) begin
            n_fail++;
            $display("FAIL random%0d: got %h required %h", i,
                     dut_vec() & exp_mask(), exp_vec() & exp_mask());
         end
      end
   endtask

   initial begin
      m_known = 1'b0;
      drive(1, 0, 0, 0, 4'h0, 16'h0, 0, 4'h0, 0, 0, 0, 16'h0);
      @(negedge clk);
      test_reset();
      test_add_flags();
      test_flag_neutral();
      test_stall_flush();
      test_halt();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline register that directly consumes the 16-bit shifter and ALU results of the execute stage.
- Latches the result and control for the memory stage.
- Owns the architectural flag register (Z, V, N) and applies per-opcode flag-update rules at capture time.
- Supports stall, flush-to-bubble, and a sticky halt that freezes instruction capture after HLT.

Parameters:
- DATA_W, 16, datapath width of result and store data.
- REG_ADDR_W, 4, destination register index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all stage state this cycle
- flush  input  1  capture a bubble instead of the EX instruction
- ex_valid  input  1  EX holds a real instruction
- ex_opcode  input  4  WISC opcode of EX instruction
- ex_result  input  DATA_W  ALU/shifter output
- ex_ovfl  input  1  signed overflow from ADD/SUB
- ex_rd  input  REG_ADDR_W  destination register
- ex_reg_write  input  1  writes register file
- ex_mem_read  input  1  load
- ex_mem_write  input  1  store
- ex_store_data  input  DATA_W  store data
- mem_valid  output  1  MEM holds a real instruction
- mem_opcode  output  4  latched opcode
- mem_result  output  DATA_W  latched result / memory address
- mem_rd  output  REG_ADDR_W  latched destination
- mem_reg_write  output  1  latched; forced 0 on bubble
- mem_mem_read  output  1  latched; forced 0 on bubble
- mem_mem_write  output  1  latched; forced 0 on bubble
- mem_store_data  output  DATA_W  latched store data
- mem_halt  output  1  sticky; set when HLT captured
- flag_z, flag_v, flag_n  output  1 each  architectural flags

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, including flags and mem_halt. Reset wins over stall and flush.
- Capture event is a posedge with rst=0, stall=0, flush=0, ex_valid=1, mem_halt=0. On a capture event:
  - all ex_* fields are registered into mem_*;
  - mem_valid=1;
  - flags update per the flag rules below.
- Bubble: any posedge with rst=0, stall=0, and no capture event.
  - mem_valid=0.
  - mem_reg_write, mem_mem_read, mem_mem_write forced to 0.
  - Data fields may hold any value.
  - Flags held.
- Stall=1 (rst=0): every register, including the flags, holds its value.
- Priority: rst > stall > flush. Stall and flush together means hold; the flush is re-presented by the hazard unit.
- Latency: exactly 1 cycle from EX inputs to mem_* outputs. Flags are visible the cycle after capture.
- Flag rules, applied only on a capture event:
  - ADD 0000, SUB 0001: Z=(ex_result==0), N=ex_result[15], V=ex_ovfl.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: Z=(ex_result==0); N and V held.
  - All other opcodes: flags held.
- Halt: capture of opcode 1111 sets mem_halt=1 and mem_valid=1 for that instruction.
  - Thereafter every non-stalled cycle is a bubble until rst.
  - mem_halt stays 1; flush does not clear it.
- No combinational path from any input to any output.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD … OP_HLT);
  - a flag-update-class function returning {upd_z, upd_n, upd_v} per opcode (also used by the branch logic).
- One sub-module is natural: flag_reg, containing the 3 flag flops with per-bit enables, stall, and sync reset.
- The pipeline fields stay in ex_mem_stage.

Test Plan:
- Reset check: rst=1 for 2 cycles, then release with stall=0, flush=0, ex_valid=0 -> every output 0 for all cycles; the ex_valid=0 cycles after release remain bubbles.
- ADD flag update: ADD, ex_result=0x8000, ex_ovfl=1 -> next cycle mem_result=0x8000, mem_valid=1, Z=0, N=1, V=1. Then SLL with ex_result=0x0000 -> Z=1, N=1, V=1 (N and V held).
- Flag-neutral opcodes: SRA with result 0x0004 -> Z=0 only. Then LW with result 0x0000 -> flags unchanged; mem_mem_read=1, mem_rd latched.
- Stall and flush: stall=1 for 3 cycles with changing ex_* inputs -> outputs frozen. Then stall=1 with flush=1 -> still frozen. Then flush=1 alone on an ADD with result 0 -> mem_valid=0, mem_reg_write=0, Z not set.
- Halt: HLT captured -> mem_halt=1, mem_valid=1. Then a valid ADD with result 0x0000 -> bubble, flags unchanged. Then rst -> mem_halt=0.
- Reset mid-stream: rst asserted with stall=1 and a valid SUB present -> next cycle all outputs 0.
